// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: serves 6-byte instruction windows out of a 32-bit word memory.
// Latency: hit -> rom_valid_o one cycle after acceptance; miss -> N+2 cycles (N = 2 or 3 word reads).
// Backpressure: none; requests seen while busy_o is high are dropped, never queued.
module inst_fetch_bridge #(
    parameter int PC_W   = 32,
    parameter int INST_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   rom_addr_i,
    input  logic              rom_req_i,
    output logic [INST_W-1:0] rom_data_o,
    output logic              rom_valid_o,
    output logic              busy_o,
    output logic [PC_W-3:0]   mem_addr_o,
    output logic              mem_rd_o,
    input  logic [31:0]       mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_addr;
    logic [1:0]          r_off;
    logic [1:0]          r_nwords;
    logic [1:0]          r_rd_cnt;
    logic [1:0]          r_cap_idx;
    logic                r_rd_d;
    logic [PC_W-3:0]     r_mem_addr;
    logic [95:0]         r_buf;
    logic [INST_W-1:0]   r_rom_data;
    logic [PC_W-1:0]     r_last_addr;
    logic                r_hit_vld;
    logic                w_hit;
    logic [95:0]         w_buf_next;
    logic [INST_W-1:0]   w_sel;

    assign w_hit      = r_hit_vld && (rom_addr_i == r_last_addr);
    assign rom_data_o = r_rom_data;
    assign mem_addr_o = r_mem_addr;

    // State register; reset aborts any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next      = r_state;
        mem_rd_o    = 1'b0;
        rom_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (rom_req_i) begin
                    w_next = w_hit ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_rd_o = 1'b1;
                if (r_rd_cnt == r_nwords - 2'd1) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                rom_valid_o = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Buffer view including the word arriving this cycle, so the last word can be used in DRAIN.
    always_comb begin
        w_buf_next = r_buf;
        if (r_rd_d) begin
            case (r_cap_idx)
                2'd0:    w_buf_next[31:0]  = mem_data_i;
                2'd1:    w_buf_next[63:32] = mem_data_i;
                default: w_buf_next[95:64] = mem_data_i;
            endcase
        end
    end

    // Byte lane select: buffer byte O lands in the top byte of the instruction window.
    always_comb begin
        w_sel = '0;
        for (int m = 0; m < INST_W / 8; m++) begin
            w_sel[INST_W-1-8*m -: 8] = w_buf_next[8*(int'(r_off) + m) +: 8];
        end
    end

    // Request latch, word address sequencing, data capture and last-served tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_off       <= '0;
            r_nwords    <= '0;
            r_rd_cnt    <= '0;
            r_cap_idx   <= '0;
            r_rd_d      <= 1'b0;
            r_mem_addr  <= '0;
            r_buf       <= '0;
            r_rom_data  <= '0;
            r_last_addr <= '0;
            r_hit_vld   <= 1'b0;
        end else begin
            r_rd_d <= (r_state == S_READ);
            if (r_rd_d) begin
                r_buf     <= w_buf_next;
                r_cap_idx <= r_cap_idx + 2'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (rom_req_i) begin
                        r_addr     <= rom_addr_i;
                        r_off      <= rom_addr_i[1:0];
                        r_nwords   <= (rom_addr_i[1:0] <= 2'd2) ? 2'd2 : 2'd3;
                        r_mem_addr <= rom_addr_i[PC_W-1:2];
                        r_rd_cnt   <= '0;
                        r_cap_idx  <= '0;
                    end
                end
                S_READ: begin
                    // Natural overflow gives the modulo-2^(PC_W-2) word wrap.
                    r_mem_addr <= r_mem_addr + 1'b1;
                    r_rd_cnt   <= r_rd_cnt + 2'd1;
                end
                S_DRAIN: begin
                    r_rom_data <= w_sel;
                end
                S_DONE: begin
                    r_last_addr <= r_addr;
                    r_hit_vld   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed vector table, reset-abort sequence, randomized traffic.
// Latency: checks cycle-exact read issue and valid timing against a byte-level reference model.
// Backpressure: exercises requests held high with changing addresses while the bridge is busy.
module tb_inst_fetch_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr_i;
    logic        rom_req_i;
    logic [47:0] rom_data_o;
    logic        rom_valid_o;
    logic        busy_o;
    logic [29:0] mem_addr_o;
    logic        mem_rd_o;
    logic [31:0] mem_data_i;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mdl_last = '0;
    bit          mdl_vld  = 1'b0;

    inst_fetch_bridge #(.PC_W(32), .INST_W(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr_i (rom_addr_i),
        .rom_req_i  (rom_req_i),
        .rom_data_o (rom_data_o),
        .rom_valid_o(rom_valid_o),
        .busy_o     (busy_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Memory: byte at address a holds a[7:0]; data appears for the whole cycle after the strobe.
    initial begin
        logic        pend_vld;
        logic [31:0] ba;
        forever begin
            @(negedge clk);
            pend_vld = mem_rd_o;
            ba       = {mem_addr_o, 2'b00};
            @(posedge clk);
            #1;
            if (pend_vld) begin
                mem_data_i = {ba[7:0] + 8'd3, ba[7:0] + 8'd2, ba[7:0] + 8'd1, ba[7:0]};
            end else begin
                mem_data_i = 32'hDEADBEEF;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Six consecutive bytes starting at a, first byte in the top lane.
    function automatic logic [47:0] model_bytes(input logic [31:0] a);
        logic [47:0] d;
        logic [31:0] b;
        d = '0;
        for (int m = 0; m < 6; m++) begin
            b = a + 32'(m);
            d[47-8*m -: 8] = b[7:0];
        end
        return d;
    endfunction

    // Issue one request (entered at posedge+1 in an idle cycle) and check the whole transaction.
    task automatic run_txn(input logic [31:0] a, input bit junk, input int exp_nrd,
                           input int exp_lat, input logic [47:0] exp_data);
        int          nrd;
        int          lat;
        bit          addr_ok;
        bit          busy_ok;
        logic [47:0] got;
        logic [29:0] w;
        w       = a[31:2];
        nrd     = 0;
        lat     = 0;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        got     = '0;
        rom_addr_i = a;
        rom_req_i  = 1'b1;
        @(negedge clk);
        if (busy_o || rom_valid_o || mem_rd_o) busy_ok = 1'b0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (junk) begin
                rom_req_i  = 1'b1;
                rom_addr_i = $urandom;
            end else begin
                rom_req_i = 1'b0;
            end
            @(negedge clk);
            if (!busy_o) busy_ok = 1'b0;
            if (mem_rd_o) begin
                if (k != nrd + 1 || mem_addr_o != w + nrd[29:0]) addr_ok = 1'b0;
                nrd++;
            end
            if (rom_valid_o) begin
                lat = k;
                got = rom_data_o;
            end
        end
        @(posedge clk);
        #1;
        rom_req_i = 1'b0;
        check($sformatf("reads@%h", a), 64'(nrd), 64'(exp_nrd));
        check($sformatf("rdaddr@%h", a), 64'(addr_ok), 64'd1);
        check($sformatf("latency@%h", a), 64'(lat), 64'(exp_lat));
        check($sformatf("data@%h", a), 64'(got), 64'(exp_data));
        check($sformatf("busy@%h", a), 64'(busy_ok), 64'd1);
        mdl_last = a;
        mdl_vld  = 1'b1;
    endtask

    // Expectations derived from the reference rules: hit if same as last served, else 2 or 3 words.
    task automatic run_pred(input logic [31:0] a, input bit junk);
        bit hit;
        int nrd;
        hit = mdl_vld && (a == mdl_last);
        nrd = hit ? 0 : ((a[1:0] <= 2'd2) ? 2 : 3);
        run_txn(a, junk, nrd, hit ? 1 : nrd + 2, model_bytes(a));
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          junk;
        int          nrd;
        int          lat;
        logic [47:0] data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit          seen_vld;
        logic [31:0] a;
        int          r;

        tbl[0] = '{32'h00000000, 1'b0, 2, 4, 48'h000102030405};
        tbl[1] = '{32'h00000003, 1'b0, 3, 5, 48'h030405060708};
        tbl[2] = '{32'h00000003, 1'b0, 0, 1, 48'h030405060708};
        tbl[3] = '{32'hFFFFFFFE, 1'b0, 2, 4, 48'hFEFF00010203};
        tbl[4] = '{32'h00000002, 1'b1, 2, 4, 48'h020304050607};
        tbl[5] = '{32'h00000002, 1'b1, 0, 1, 48'h020304050607};
        tbl[6] = '{32'h00000101, 1'b0, 2, 4, 48'h010203040506};
        tbl[7] = '{32'h00000003, 1'b0, 3, 5, 48'h030405060708};

        rst        = 1'b1;
        rom_req_i  = 1'b0;
        rom_addr_i = '0;
        mem_data_i = '0;
        #1;
        check("rst_valid", 64'(rom_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_memrd", 64'(mem_rd_o), 64'd0);
        check("rst_memaddr", 64'(mem_addr_o), 64'd0);
        check("rst_data", 64'(rom_data_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].addr, tbl[i].junk, tbl[i].nrd, tbl[i].lat, tbl[i].data);
        end

        // Serve 0x20, then reset in the middle of a miss for 0x10.
        run_pred(32'h00000020, 1'b0);
        rom_addr_i = 32'h00000010;
        rom_req_i  = 1'b1;
        @(posedge clk);
        #1;
        rom_req_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_memrd", 64'(mem_rd_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_valid", 64'(rom_valid_o), 64'd0);
        check("midrst_data", 64'(rom_data_o), 64'd0);
        check("midrst_memaddr", 64'(mem_addr_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rom_valid_o || busy_o) seen_vld = 1'b1;
        end
        check("midrst_quiet", 64'(seen_vld), 64'd0);
        mdl_vld = 1'b0;
        @(posedge clk);
        #1;
        run_pred(32'h00000020, 1'b0);
        run_pred(32'h00000010, 1'b0);

        // Randomized traffic mixing hits, wrap-around addresses and requests held during busy.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       a = mdl_vld ? mdl_last : $urandom;
                1:       a = $urandom;
                2:       a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 15));
            endcase
            run_pred(a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("hold_valid", 64'(rom_valid_o), 64'd0);
                check("hold_data", 64'(rom_data_o), 64'(model_bytes(mdl_last)));
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
